// File: rtl/fpu_pkg.sv
// Shared FPU types: field widths, the 34-bit add bus consumed by fpu_norm,
// and the add/sub core state encoding.
package fpu_pkg;
  localparam int EXP_W         = 8;
  localparam int FRAC_W        = 23;
  localparam int MANT_W        = FRAC_W + 1;
  localparam int MAX_SHIFT_DEF = 25;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W:0]   mant;   // [24] carry, [23] hidden bit
  } add_bus_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ALIGN = 2'd1,
    ST_ADD   = 2'd2
  } addsub_state_t;
endpackage

// File: rtl/fpu_align_shift.sv
// Holds the smaller operand's mantissa and right-aligns it by the shift amount.
// FPU_BARREL_ALIGN_EN: whole shift in one step; otherwise one bit per step.
module fpu_align_shift
  import fpu_pkg::*;
#(
  parameter int SHW = 5
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load,
  input  logic [MANT_W-1:0] mant_in,
  input  logic [SHW-1:0]    shamt,
  input  logic              step,
  output logic [MANT_W-1:0] mant,
  output logic              done
);
`ifdef FPU_BARREL_ALIGN_EN
  logic [SHW-1:0] amt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mant <= '0;
      amt  <= '0;
    end else if (load) begin
      mant <= mant_in;
      amt  <= shamt;
    end else if (step) begin
      mant <= mant >> amt;
      amt  <= '0;   // a repeated step must not shift twice
    end
  end

  assign done = 1'b1;
`else
  logic [SHW-1:0] cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mant <= '0;
      cnt  <= '0;
    end else if (load) begin
      mant <= mant_in;
      cnt  <= shamt;
    end else if (step && cnt != '0) begin
      mant <= mant >> 1;
      cnt  <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);
`endif
endmodule

// File: rtl/fpu_addsub_core.sv
// Single-precision add/sub front end: unpack, magnitude swap, align, mantissa add.
// Produces the raw add bus for fpu_norm. Optional macro: FPU_BARREL_ALIGN_EN.
module fpu_addsub_core
  import fpu_pkg::*;
#(
  parameter int MAX_SHIFT = MAX_SHIFT_DEF
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic        op_sub_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        busy_o,
  output logic        valid_o,
  output logic [33:0] add_o
);
  localparam int SHW = $clog2(MAX_SHIFT + 1);
  localparam logic [EXP_W-1:0] MAX_E = EXP_W'(MAX_SHIFT);
  localparam logic [SHW-1:0]   MAX_N = SHW'(MAX_SHIFT);

  addsub_state_t state, state_nx;

  logic              sign_l, eff_sub;
  logic [EXP_W-1:0]  exp_l;
  logic [MANT_W-1:0] mant_l;
  add_bus_t          add_q;
  logic              valid_q;

  // Unpack; zero exponent flushes the mantissa
  logic [EXP_W-1:0]  exp_a, exp_b, exp_ln, exp_sn, diff;
  logic [MANT_W-1:0] mant_a, mant_b, mant_ln, mant_sn;
  logic              sign_a, sign_b, sign_ln, a_is_l;
  logic [SHW-1:0]    shamt;

  always_comb begin
    exp_a   = a_i[30:23];
    exp_b   = b_i[30:23];
    mant_a  = (exp_a != '0) ? {1'b1, a_i[22:0]} : '0;
    mant_b  = (exp_b != '0) ? {1'b1, b_i[22:0]} : '0;
    sign_a  = a_i[31];
    sign_b  = b_i[31] ^ op_sub_i;
    a_is_l  = {exp_a, mant_a} >= {exp_b, mant_b};
    exp_ln  = a_is_l ? exp_a  : exp_b;
    exp_sn  = a_is_l ? exp_b  : exp_a;
    mant_ln = a_is_l ? mant_a : mant_b;
    mant_sn = a_is_l ? mant_b : mant_a;
    sign_ln = a_is_l ? sign_a : sign_b;
    diff    = exp_ln - exp_sn;
    shamt   = (diff > MAX_E) ? MAX_N : diff[SHW-1:0];
  end

  logic              load, step, done;
  logic [MANT_W-1:0] mant_s;

  fpu_align_shift #(.SHW(SHW)) u_align (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .load    (load),
    .mant_in (mant_sn),
    .shamt   (shamt),
    .step    (step),
    .mant    (mant_s),
    .done    (done)
  );

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    step     = 1'b0;
    case (state)
      ST_IDLE: if (start_i) begin
        load     = 1'b1;
        state_nx = ST_ALIGN;
      end
      ST_ALIGN: begin
        step = 1'b1;
        if (done) state_nx = ST_ADD;
      end
      ST_ADD:  state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // L magnitude >= S, so the difference never goes negative
  logic [MANT_W:0] sum;
  add_bus_t        res;

  always_comb begin
    sum = eff_sub ? ({1'b0, mant_l} - {1'b0, mant_s})
                  : ({1'b0, mant_l} + {1'b0, mant_s});
    res = '{sign: sign_l, exp: exp_l, mant: sum};
    if (eff_sub && sum == '0) res = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= ST_IDLE;
      sign_l  <= 1'b0;
      eff_sub <= 1'b0;
      exp_l   <= '0;
      mant_l  <= '0;
      add_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state   <= state_nx;
      valid_q <= (state == ST_ADD);
      if (load) begin
        sign_l  <= sign_ln;
        eff_sub <= sign_a ^ sign_b;
        exp_l   <= exp_ln;
        mant_l  <= mant_ln;
      end
      if (state == ST_ADD) add_q <= res;
    end
  end

  assign busy_o  = (state != ST_IDLE);
  assign valid_o = valid_q;
  assign add_o   = add_q;
endmodule

// File: tb/tb_fpu_addsub_core.sv
// Directed-vector bench for fpu_addsub_core: results, latency, busy/valid
// protocol, start-while-busy, mid-op reset and back-to-back issue.
module tb_fpu_addsub_core;
  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_i = 1'b0;
  logic        op_sub_i = 1'b0;
  logic [31:0] a_i = '0;
  logic [31:0] b_i = '0;
  logic        busy_o, valid_o;
  logic [33:0] add_o;

  int n_chk  = 0;
  int n_pass = 0;

  fpu_addsub_core dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .start_i  (start_i),
    .op_sub_i (op_sub_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .busy_o   (busy_o),
    .valid_o  (valid_o),
    .add_o    (add_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [33:0] got, input logic [33:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic int lat_of(input int n);
`ifdef FPU_BARREL_ALIGN_EN
    return 2;
`else
    return n + 2;
`endif
  endfunction

  function automatic logic [33:0] bus(input logic s, input logic [7:0] e, input logic [24:0] m);
    return {s, e, m};
  endfunction

  // Issue at #1 after an edge; count edges until valid_o. Optionally poke
  // start_i with different operands while the op is in flight.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic sub, input logic [33:0] exp_res, input int exp_lat,
                        input bit poke);
    int lat;
    a_i = a; b_i = b; op_sub_i = sub; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    chk({tag, "_busy"}, 34'(busy_o), 34'd1);
    lat = 0;
    do begin
      if (poke && lat == 1) begin
        start_i = 1'b1; a_i = 32'h40400000; b_i = 32'h40400000; op_sub_i = 1'b0;
      end else start_i = 1'b0;
      @(posedge clk_i); #1;
      lat++;
    end while (!valid_o && lat < 40);
    start_i = 1'b0;
    chk({tag, "_lat"}, 34'(lat), 34'(exp_lat));
    chk({tag, "_res"}, add_o, exp_res);
    chk({tag, "_idle"}, 34'(busy_o), 34'd0);
  endtask

  initial begin
    int lat;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_add", add_o, 34'd0);
    chk("rst_busy", 34'(busy_o), 34'd0);
    chk("rst_valid", 34'(valid_o), 34'd0);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    run_op("one_plus_one", 32'h3F800000, 32'h3F800000, 1'b0, bus(1'b0, 8'h7F, 25'h1000000), lat_of(0), 1'b0);
    @(posedge clk_i); #1;
    chk("valid_pulse", 34'(valid_o), 34'd0);
    chk("hold_result", add_o, bus(1'b0, 8'h7F, 25'h1000000));
    run_op("one_minus_one", 32'h3F800000, 32'h3F800000, 1'b1, 34'd0, lat_of(0), 1'b0);
    run_op("three_plus_one", 32'h40400000, 32'h3F800000, 1'b0, bus(1'b0, 8'h80, 25'h1000000), lat_of(1), 1'b0);
    run_op("clamp", 32'h3F800000, 32'h0F000000, 1'b0, bus(1'b0, 8'h7F, 25'h0800000), lat_of(25), 1'b0);
    run_op("swap_sub", 32'h3F800000, 32'h40000000, 1'b1, bus(1'b1, 8'h80, 25'h0400000), lat_of(1), 1'b0);
    // second start pulse mid-flight must neither restart nor corrupt the op
    run_op("busy_ignore", 32'h3F800000, 32'h0F000000, 1'b0, bus(1'b0, 8'h7F, 25'h0800000), lat_of(25), 1'b1);

    // back-to-back: start in the valid_o cycle of the previous op
    run_op("b2b_first", 32'h40400000, 32'h3F800000, 1'b0, bus(1'b0, 8'h80, 25'h1000000), lat_of(1), 1'b0);
    a_i = 32'h3F800000; b_i = 32'h40000000; op_sub_i = 1'b1; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    chk("b2b_accept", 34'(busy_o), 34'd1);
    lat = 0;
    do begin
      @(posedge clk_i); #1;
      lat++;
    end while (!valid_o && lat < 40);
    chk("b2b_lat", 34'(lat), 34'(lat_of(1)));
    chk("b2b_res", add_o, bus(1'b1, 8'h80, 25'h0400000));

    // reset mid-operation aborts with no valid_o
    a_i = 32'h3F800000; b_i = 32'h0F000000; op_sub_i = 1'b0; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_busy", 34'(busy_o), 34'd0);
    chk("mid_rst_valid", 34'(valid_o), 34'd0);
    chk("mid_rst_add", add_o, 34'd0);
    repeat (3) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    lat = 0;
    repeat (30) begin
      @(posedge clk_i); #1;
      if (valid_o) lat++;
    end
    chk("mid_rst_novalid", 34'(lat), 34'd0);
    run_op("post_rst", 32'h40400000, 32'h3F800000, 1'b0, bus(1'b0, 8'h80, 25'h1000000), lat_of(1), 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
